// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_WAIT_STATES = 15;

  function automatic int cnt_width();
    return $clog2(MAX_WAIT_STATES + 1);
  endfunction

  localparam int CNT_W = cnt_width();

endpackage

// File: rtl/dmem_sram_array.sv
// rtl/dmem_sram_array.sv - single-port word RAM with byte enables and registered read
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // No reset on the array or its output register so the tools can map it to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-bus responder: wait-state FSM, address decode, response register
// Optional DMEM_BUSERR_EN adds the bus_err output flagging out-of-window accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        mem_rd_wr,
  input  logic [3:0]  mask,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_valid
`ifdef DMEM_BUSERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int          AW           = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_q, hit_q;
  logic [3:0]       mask_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q, hold_q;

  logic [31:0]      offset;
  logic             hit, accept;
  logic [AW-1:0]    idx;
  logic             sram_we, sram_re;
  logic [AW-1:0]    sram_addr;
  logic [31:0]      sram_rdata;
  logic             unused_offset_bits;

  // Unsigned wrap makes addresses below ADDR_BASE land far outside the window.
  assign offset             = mem_addr - ADDR_BASE;
  assign hit                = offset < WINDOW_BYTES;
  assign idx                = offset[AW+1:2];
  assign unused_offset_bits = ^offset[1:0];
  assign accept             = (state_q == IDLE) && cs;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      hit_q   <= 1'b0;
      mask_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q    <= mem_rd_wr;
        hit_q   <= hit;
        mask_q  <= mask;
        idx_q   <= idx;
        wdata_q <= mem_write_data;
        cnt_q   <= (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == RESP) hold_q <= mem_read_data;
    end
  end

  // The RAM read is launched on the edge entering RESP so its registered word is ready in RESP;
  // with zero wait states that edge is the acceptance edge, hence the live index in IDLE.
  assign sram_addr = (state_q == IDLE) ? idx : idx_q;
  assign sram_re   = (state_d == RESP) &&
                     ((state_q == IDLE) ? (mem_rd_wr && hit) : (rd_q && hit_q));
  assign sram_we   = (state_q == RESP) && !rd_q && hit_q;

  dmem_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .re    (sram_re),
    .be    (mask_q),
    .addr  (sram_addr),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  assign mem_valid = (state_q == RESP);

  always_comb begin
    mem_read_data = hold_q;
    if (state_q == RESP && rd_q) mem_read_data = hit_q ? sram_rdata : 32'h0;
  end

`ifdef DMEM_BUSERR_EN
  assign bus_err = (state_q == RESP) && !hit_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder with wait states 1, 0 and 3
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_r   [3] = '{1'b1, 1'b1, 1'b1};
  logic        cs_r    [3] = '{1'b0, 1'b0, 1'b0};
  logic        rd_r    [3] = '{1'b0, 1'b0, 1'b0};
  logic [3:0]  mask_r  [3] = '{4'h0, 4'h0, 4'h0};
  logic [31:0] addr_r  [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] wdata_r [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] rdata_w [3];
  logic        valid_w [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int WS = (k == 0) ? 1 : ((k == 1) ? 0 : 3);

    dmem_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_STATES (WS),
      .ADDR_BASE   (32'h0)
    ) u_dut (
      .clk            (clk),
      .reset          (rst_r[k]),
      .cs             (cs_r[k]),
      .mem_rd_wr      (rd_r[k]),
      .mask           (mask_r[k]),
      .mem_addr       (addr_r[k]),
      .mem_write_data (wdata_r[k]),
      .mem_read_data  (rdata_w[k]),
      .mem_valid      (valid_w[k])
    );

    // Transaction-level model: a request is busy until its response cycle, writes land then.
    int          cyc = 0;
    int          resp_at = -1;
    bit          pend = 1'b0;
    bit          p_rd;
    logic [3:0]  p_mask;
    logic [31:0] p_addr, p_wdata;
    bit          exp_valid = 1'b0;
    bit          exp_known = 1'b1;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] mm [int];
    int          idx;
    logic [31:0] w;
    bit          prev_v = 1'b0;

    always @(posedge clk or posedge rst_r[k]) begin
      if (rst_r[k]) begin
        pend      = 1'b0;
        exp_rdata = 32'h0;
        exp_known = 1'b1;
      end else if (pend) begin
        if (resp_at == cyc) begin
          if (!p_rd && p_addr < 32'd4096) begin
            idx = int'(p_addr >> 2);
            if (mm.exists(idx)) begin
              w = mm[idx];
              for (int b = 0; b < 4; b++) if (p_mask[b]) w[8*b +: 8] = p_wdata[8*b +: 8];
              mm[idx] = w;
            end else if (p_mask == 4'hF) begin
              mm[idx] = p_wdata;
            end
          end
          pend = 1'b0;
        end
      end else if (cs_r[k]) begin
        pend    = 1'b1;
        resp_at = cyc + WS + 1;
        p_rd    = rd_r[k];
        p_mask  = mask_r[k];
        p_addr  = addr_r[k];
        p_wdata = wdata_r[k];
      end
      cyc++;
      exp_valid = pend && (resp_at == cyc);
      if (exp_valid && p_rd) begin
        if (p_addr < 32'd4096) begin
          idx       = int'(p_addr >> 2);
          exp_known = mm.exists(idx);
          exp_rdata = exp_known ? mm[idx] : 32'h0;
        end else begin
          exp_rdata = 32'h0;
          exp_known = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("valid%0d", k), 32'(valid_w[k]), 32'(exp_valid));
      if (exp_known) check($sformatf("rdata%0d", k), rdata_w[k], exp_rdata);
      check($sformatf("double_valid%0d", k), 32'(prev_v & valid_w[k]), 32'h0);
      prev_v = valid_w[k];
    end
  end

  task automatic do_req(input int k, input bit rd, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdat, output int lat);
    cs_r[k] = 1'b1; rd_r[k] = rd; mask_r[k] = m; addr_r[k] = a; wdata_r[k] = wd;
    lat  = -1;
    rdat = 32'h0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid_w[k]) begin
        lat  = n;
        rdat = rdata_w[k];
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) check($sformatf("timeout%0d", k), 32'h0, 32'h1);
    @(posedge clk); #1;
    cs_r[k] = 1'b0;
  endtask

  task automatic req(input int k, input bit rd, input logic [3:0] m, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input string nm);
    logic [31:0] d;
    int          lat;
    do_req(k, rd, m, a, wd, d, lat);
    check({nm, "_lat"}, lat, ws_of(k) + 1);
    check({nm, "_data"}, d, exp_d);
  endtask

  logic [5:0]  burst_v;
  logic [31:0] burst_d [6];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_w[0]), 32'h0);
    check("reset_rdata", rdata_w[0], 32'h0);
    for (int k = 0; k < 3; k++) rst_r[k] = 1'b0;

    // wait states 1
    req(0, 0, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        "w10");
    req(0, 1, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, "r10");
    req(0, 1, 4'h0, 32'h13,   32'h0,        32'hDEADBEEF, "r13");
    req(0, 0, 4'hF, 32'h20,   32'h11223344, 32'hDEADBEEF, "w20");
    req(0, 0, 4'h5, 32'h20,   32'hAABBCCDD, 32'hDEADBEEF, "w20m");
    req(0, 1, 4'hF, 32'h20,   32'h0,        32'h11BB33DD, "r20");
    req(0, 0, 4'hF, 32'h0,    32'h0BADF00D, 32'h11BB33DD, "w0");
    req(0, 1, 4'hF, 32'h1000, 32'h0,        32'h0,        "rmiss");
    req(0, 0, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0,        "wmiss");
    req(0, 1, 4'hF, 32'h0,    32'h0,        32'h0BADF00D, "r0");
    req(0, 1, 4'hF, 32'hFFFFFFFC, 32'h0,    32'h0,        "rwrap");
    req(0, 0, 4'hF, 32'h4,    32'hCAFE0004, 32'h0,        "w4");
    req(0, 1, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, "r10b");
    req(0, 0, 4'h0, 32'h4,    32'h12345678, 32'hDEADBEEF, "w4m0");
    req(0, 1, 4'hF, 32'h4,    32'h0,        32'hCAFE0004, "r4");

    // zero wait states, cs held across a burst of reads
    req(1, 0, 4'hF, 32'h40, 32'h11111111, 32'h0, "w40");
    req(1, 0, 4'hF, 32'h44, 32'h22222222, 32'h0, "w44");
    cs_r[1] = 1'b1; rd_r[1] = 1'b1; mask_r[1] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      addr_r[1] = (i == 2 || i == 3) ? 32'h44 : 32'h40;
      @(negedge clk);
      burst_v[i] = valid_w[1];
      burst_d[i] = rdata_w[1];
      @(posedge clk); #1;
    end
    cs_r[1] = 1'b0;
    check("burst_valid", 32'(burst_v), 32'h2A);
    check("burst_d2", burst_d[1], 32'h11111111);
    check("burst_d4", burst_d[3], 32'h22222222);
    check("burst_d6", burst_d[5], 32'h11111111);

    // three wait states, reset lands in the middle of a pending write
    req(2, 0, 4'hF, 32'h8, 32'h00000055, 32'h0,        "w8");
    req(2, 1, 4'hF, 32'h8, 32'h0,        32'h00000055, "r8");
    cs_r[2] = 1'b1; rd_r[2] = 1'b0; mask_r[2] = 4'hF; addr_r[2] = 32'h8; wdata_r[2] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_r[2] = 1'b1;
    cs_r[2]  = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(valid_w[2]), 32'h0);
    check("rst_mid_rdata", rdata_w[2], 32'h0);
    @(posedge clk); #1;
    rst_r[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_quiet", 32'(valid_w[2]), 32'h0);
    end
    @(posedge clk); #1;
    req(2, 1, 4'hF, 32'h8, 32'h0, 32'h00000055, "r8_after_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", 32'h0, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
